// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED step sequencer.
//   seq_state_t : 3-bit FSM state encoding
//   AMT_LSB/AMT_MSB/PAT_LSB : field positions inside a ROM step word
//   END_MARKER  : amount value that terminates the program
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_HALT  = 3'd5
  } seq_state_t;

  localparam int AMT_LSB = 0;
  localparam int AMT_MSB = 7;
  localparam int PAT_LSB = 8;

  localparam logic [7:0] END_MARKER = 8'h00;

endpackage

// File: rtl/led_step_sequencer.sv
// led_step_sequencer: fetches {pattern, amount} step words from a synchronous
// ROM, drives the LED pattern and handshakes with the delay timer.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   run          level; 1 = execute program, 0 = pause
//   rom_addr     step address to the ROM (registered)
//   rom_data     ROM word {pattern, amount}, valid one cycle after rom_addr
//   leds         current LED pattern
//   timer_start  drives timer startStop
//   timer_amount drives timer amount
//   timer_en     one-cycle done pulse from the timer
//   step_pulse   one-cycle pulse when a step completes
//   halted       end marker reached (always 0 in the looping build)
//
// Build option: LED_SEQ_LOOP_EN -- when defined, the end marker restarts the
// program at address 0 instead of halting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | paused / after reset; timer stopped, waits for run
// FETCH | rom_addr presented, waiting out the ROM read latency
// LOAD  | rom_data valid; start a step or act on the end marker
// WAIT  | timer running, waiting for its done pulse
// GAP   | timer held stopped one cycle so it clears its count
// HALT  | end marker reached; only reset leaves this state
module led_step_sequencer
  import led_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LED_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LED_W+7:0]  rom_data,
  output logic [LED_W-1:0]  leds,
  output logic              timer_start,
  output logic [7:0]        timer_amount,
  input  logic              timer_en,
  output logic              step_pulse,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  seq_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        rom_amt;
  logic [LED_W-1:0]  rom_pat;

  assign rom_amt = rom_data[AMT_MSB:AMT_LSB];
  assign rom_pat = rom_data[PAT_LSB +: LED_W];

`ifndef LED_SEQ_LOOP_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      pc           <= '0;
      rom_addr     <= '0;
      leds         <= '0;
      timer_start  <= 1'b0;
      timer_amount <= 8'h00;
      step_pulse   <= 1'b0;
`ifndef LED_SEQ_LOOP_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer_start <= 1'b0;
          if (run) begin
            rom_addr <= pc;
            state    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (!run) begin
            timer_start <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!run) begin
            timer_start <= 1'b0;
            state       <= ST_IDLE;
          end else if (rom_amt != END_MARKER) begin
            leds         <= rom_pat;
            timer_amount <= rom_amt;
            timer_start  <= 1'b1;
            state        <= ST_WAIT;
          end else begin
            // End marker: pattern field is ignored, leds keep the last step.
`ifdef LED_SEQ_LOOP_EN
            pc       <= '0;
            rom_addr <= '0;
            state    <= ST_FETCH;
`else
            timer_start <= 1'b0;
            halted_q    <= 1'b1;
            state       <= ST_HALT;
`endif
          end
        end

        ST_WAIT: begin
          // run has priority over a coincident done pulse: the step is
          // abandoned and re-timed from zero on resume.
          if (!run) begin
            timer_start <= 1'b0;
            state       <= ST_IDLE;
          end else if (timer_en) begin
            timer_start <= 1'b0;
            step_pulse  <= 1'b1;
            pc          <= pc + PC_ONE;
            state       <= ST_GAP;
          end
        end

        ST_GAP: begin
          timer_start <= 1'b0;
          if (!run) begin
            state <= ST_IDLE;
          end else begin
            rom_addr <= pc;
            state    <= ST_FETCH;
          end
        end

        ST_HALT: begin
          timer_start <= 1'b0;
        end

        default: begin
          timer_start <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_step_sequencer.sv
// tb_led_step_sequencer: directed bench for led_step_sequencer with a
// behavioural synchronous ROM and a behavioural delay timer model.
// Works in both the default (halting) and LED_SEQ_LOOP_EN builds.
module tb_led_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic [7:0]  leds;
  logic        timer_start;
  logic [7:0]  timer_amount;
  logic        timer_en;
  logic        step_pulse;
  logic        halted;

  logic [15:0] rom [32];

  // timer model: en pulses once after 'amount' cycles of startStop=1,
  // counter clears whenever startStop is 0
  logic [7:0] tcnt   = 8'h00;
  logic       tdone  = 1'b0;
  logic       tmr_en = 1'b0;
  logic       inj    = 1'b0;

  int total = 0;
  int bad   = 0;

  assign timer_en = tmr_en | inj;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (!timer_start) begin
      tcnt   <= 8'h00;
      tdone  <= 1'b0;
      tmr_en <= 1'b0;
    end else begin
      tcnt <= tcnt + 8'd1;
      if (!tdone && tcnt == timer_amount - 8'd1) begin
        tmr_en <= 1'b1;
        tdone  <= 1'b1;
      end else begin
        tmr_en <= 1'b0;
      end
    end
  end

  led_step_sequencer #(.ADDR_W(5), .LED_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .leds         (leds),
    .timer_start  (timer_start),
    .timer_amount (timer_amount),
    .timer_en     (timer_en),
    .step_pulse   (step_pulse),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    run = 1'b1;
    inj = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load_rom_b();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = {8'h11, 8'h02};
    rom[1] = {8'h22, 8'h05};
    rom[2] = {8'h00, 8'h00};
  endtask

  initial begin
    int n;
    int sp;
    int enw;
    int nseq;
    int hcnt;
    int tson;
    logic prev_ts;
    logic seen;
    logic wrapped;
    logic [7:0] seq [4];

    // ---------------- reset and first step ----------------
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = {8'hA5, 8'h03};
    rom[1] = {8'h5A, 8'h02};
    run = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    check("rst_leds",   32'(leds), 32'h0);
    check("rst_ts",     32'(timer_start), 32'h0);
    check("rst_amt",    32'(timer_amount), 32'h0);
    check("rst_addr",   32'(rom_addr), 32'h0);
    check("rst_pulse",  32'(step_pulse), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    rst = 1'b1;
    tick();
    check("t1_ts_c1", 32'(timer_start), 32'h0);
    tick();
    tick();
    check("t1_leds_c3", 32'(leds), 32'hA5);
    check("t1_ts_c3",   32'(timer_start), 32'h1);
    check("t1_amt_c3",  32'(timer_amount), 32'h03);
    n = 0;
    while (!timer_en && n < 20) begin tick(); n++; end
    check("t1_delay", 32'(n), 32'd3);
    tick();
    check("t1_pulse",  32'(step_pulse), 32'h1);
    check("t1_ts_off", 32'(timer_start), 32'h0);
    tick();
    check("t1_pulse_1cyc", 32'(step_pulse), 32'h0);
    check("t1_addr_next",  32'(rom_addr), 32'h1);

    // ---------------- end marker: loop or halt ----------------
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = {8'h11, 8'h02};
    rom[1] = {8'h22, 8'h01};
    rom[2] = {8'h00, 8'h00};
    reset_dut();
    nseq = 0; hcnt = 0; sp = 0;
    prev_ts = 1'b0; seen = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 8'h00;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (timer_start && !prev_ts && nseq < 4) begin
        seq[nseq] = leds;
        nseq++;
      end
      prev_ts = timer_start;
      if (rom_addr == 5'd2) seen = 1'b1;
      if (seen && rom_addr == 5'd0) wrapped = 1'b1;
      if (halted) hcnt++;
      if (step_pulse) sp++;
    end
`ifdef LED_SEQ_LOOP_EN
    check("t2_nseq",   32'(nseq), 32'd4);
    check("t2_seq0",   32'(seq[0]), 32'h11);
    check("t2_seq1",   32'(seq[1]), 32'h22);
    check("t2_seq2",   32'(seq[2]), 32'h11);
    check("t2_seq3",   32'(seq[3]), 32'h22);
    check("t2_wrap0",  32'(wrapped), 32'h1);
    check("t2_nohalt", 32'(hcnt), 32'h0);
`else
    check("t2_nseq",   32'(nseq), 32'd2);
    check("t2_seq0",   32'(seq[0]), 32'h11);
    check("t2_seq1",   32'(seq[1]), 32'h22);
    check("t2_pulses", 32'(sp), 32'd2);
    check("t2_leds",   32'(leds), 32'h22);
    check("t2_halted", 32'(halted), 32'h1);
    check("t2_addr",   32'(rom_addr), 32'h2);
    tson = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (timer_start) tson++;
    end
    check("t2_ts_quiet", 32'(tson), 32'h0);
    check("t2_halt_hold", 32'(halted), 32'h1);
`endif

    // ---------------- run dropped mid-WAIT of step 1 ----------------
    load_rom_b();
    reset_dut();
    n = 0;
    while (!(timer_start && leds == 8'h22) && n < 40) begin tick(); n++; end
    check("t3_reach", 32'(n < 40), 32'h1);
    tick();
    tick();
    run = 1'b0;
    tick();
    check("t3_ts_drop", 32'(timer_start), 32'h0);
    check("t3_pc_hold", 32'(rom_addr), 32'h1);
    check("t3_leds",    32'(leds), 32'h22);
    sp = 32'(step_pulse);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (step_pulse) sp++;
    end
    check("t3_no_pulse", 32'(sp), 32'h0);
    run = 1'b1;
    n = 0;
    while (!timer_start && n < 20) begin tick(); n++; end
    check("t3_restart", 32'(n), 32'd3);
    check("t3_addr",    32'(rom_addr), 32'h1);
    n = 0;
    while (!timer_en && n < 20) begin tick(); n++; end
    check("t3_full_delay", 32'(n), 32'd5);
    // run low in the same cycle as the done pulse
    run = 1'b0;
    tick();
    check("t3_race_pulse", 32'(step_pulse), 32'h0);
    check("t3_race_ts",    32'(timer_start), 32'h0);
    run = 1'b1;
    tick();
    check("t3_race_pc", 32'(rom_addr), 32'h1);
    n = 0;
    while (!step_pulse && n < 30) begin tick(); n++; end
    check("t3_redo", 32'(n), 32'd8);
    check("t3_leds_after", 32'(leds), 32'h22);

    // ---------------- stale timer_en in GAP/FETCH ----------------
    load_rom_b();
    reset_dut();
    n = 0;
    while (!step_pulse && n < 30) begin tick(); n++; end
    check("t4_first_step", 32'(n < 30), 32'h1);
    inj = 1'b1;
    tick();
    check("t4_gap_pulse", 32'(step_pulse), 32'h0);
    check("t4_gap_addr",  32'(rom_addr), 32'h1);
    tick();
    check("t4_fetch_pulse", 32'(step_pulse), 32'h0);
    inj = 1'b0;
    tick();
    check("t4_load_leds", 32'(leds), 32'h22);
    check("t4_load_ts",   32'(timer_start), 32'h1);
    check("t4_load_addr", 32'(rom_addr), 32'h1);
    n = 0;
    while (!timer_en && n < 20) begin tick(); n++; end
    check("t4_delay", 32'(n), 32'd5);

    // ---------------- pc wrap over full address space ----------------
    for (int i = 0; i < 32; i++) rom[i] = {8'(i), 8'h01};
    reset_dut();
    n = 0; sp = 0; enw = 0; seen = 1'b0;
    while (n < 400) begin
      tick();
      n++;
      if (step_pulse) sp++;
      if (timer_en && timer_start) enw++;
      if (rom_addr == 5'd31) seen = 1'b1;
      if (seen && rom_addr == 5'd0) break;
    end
    check("t5_wrapped", 32'(n < 400), 32'h1);
    check("t5_pulses",  32'(sp), 32'd32);
    check("t5_en_wait", 32'(enw), 32'd32);
    check("t5_leds",    32'(leds), 32'h1F);
    check("t5_halted",  32'(halted), 32'h0);
    n = 0;
    while (!timer_start && n < 10) begin tick(); n++; end
    check("t5_restart", 32'(n), 32'd2);
    check("t5_leds0",   32'(leds), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
